// File: rtl/ecc_pkg.sv
// Shared SECDED definitions: Hamming code with an extra overall-parity bit
// stored at codeword bit 0, plus the scrub-memory FSM state type.
package ecc_pkg;

  function automatic int calc_m(input int k);
    int m;
    m = 1;
    while ((1 << m) < (m + k + 1)) m = m + 1;
    return m;
  endfunction

  localparam int DATA_W = 8;
  localparam int PAR_W  = calc_m(DATA_W);
  localparam int CW     = PAR_W + DATA_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HRD,
    ST_HWB,
    ST_SRD,
    ST_SWB
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sb;
    logic              db;
  } dec_t;

  function automatic logic is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Data occupies the non-power-of-two positions 1..CW-1 in ascending order.
  function automatic logic [CW-1:0] secded_encode(input logic [DATA_W-1:0] data);
    logic [CW-1:0] cw;
    logic          par;
    int            k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if (!is_pow2(pos)) begin
        cw[pos] = data[k];
        k = k + 1;
      end
    end
    for (int p = 0; p < PAR_W; p++) begin
      par = 1'b0;
      for (int pos = 1; pos < CW; pos++) begin
        if ((pos & (1 << p)) != 0) par = par ^ cw[pos];
      end
      cw[1 << p] = par;
    end
    cw[0] = ^cw[CW-1:1];
    return cw;
  endfunction

  // A syndrome pointing past the codeword still counts as single-bit, but
  // nothing is flipped.
  function automatic dec_t secded_decode(input logic [CW-1:0] cw);
    dec_t           res;
    logic [PAR_W-1:0] syn;
    logic           ovr;
    logic [CW-1:0]  fixed;
    int             k;
    syn = '0;
    for (int p = 0; p < PAR_W; p++) begin
      for (int pos = 1; pos < CW; pos++) begin
        if ((pos & (1 << p)) != 0) syn[p] = syn[p] ^ cw[pos];
      end
    end
    ovr   = ^cw;
    fixed = cw;
    if (ovr && (int'(syn) < CW)) fixed[syn] = ~fixed[syn];
    res.sb   = ovr;
    res.db   = !ovr && (syn != '0);
    res.data = '0;
    k = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if (!is_pow2(pos)) begin
        res.data[k] = fixed[pos];
        k = k + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ecc_sat_counter.sv
// Event counter that sticks at all-ones; a clear wins over a same-cycle increment.
module ecc_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ecc_scrub_mem.sv
// SECDED word store with host read correction/write-back and a periodic
// background scrubber that repairs latent single-bit upsets.
module ecc_scrub_mem
  import ecc_pkg::*;
#(
  parameter int K              = DATA_W,
  parameter int DEPTH          = 16,
  parameter int SCRUB_INTERVAL = 256,
  parameter int AW             = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [K-1:0]  wdata_i,
  output logic          gnt_o,
  output logic          rvalid_o,
  output logic [K-1:0]  rdata_o,
  output logic          rerr_sb_o,
  output logic          rerr_db_o,
  input  logic          scrub_en_i,
  input  logic          inj_i,
  input  logic [AW-1:0] inj_addr_i,
  input  logic [CW-1:0] inj_mask_i,
  input  logic          clr_i,
  output logic [15:0]   sb_cnt_o,
  output logic [15:0]   db_cnt_o,
  output logic [AW-1:0] db_addr_o,
  output logic          irq_db_o
);

  localparam int          TW   = $clog2(SCRUB_INTERVAL);
  localparam logic [TW-1:0] TMAX = TW'(SCRUB_INTERVAL - 1);

  state_e        state_d, state_q;
  logic [TW-1:0] timer_d, timer_q;
  logic [AW-1:0] ptr_d, ptr_q;
  logic [AW-1:0] haddr_d, haddr_q;
  logic [CW-1:0] hcw_d, hcw_q;
  logic [CW-1:0] wb_cw_d, wb_cw_q;
  logic [AW-1:0] db_addr_d, db_addr_q;
  logic          irq_d, irq_q;
  logic [CW-1:0] mem_d [DEPTH];
  logic [CW-1:0] mem_q [DEPTH];

  logic          host_wr, wb_en, sb_ev, db_ev;
  logic [AW-1:0] wb_addr, ev_addr;
  logic [CW-1:0] dec_in;
  dec_t          dec;

  // One shared decoder: scrub reads the array directly, host reads use the captured word.
  assign dec_in = (state_q == ST_SRD) ? mem_q[ptr_q] : hcw_q;
  assign dec    = secded_decode(dec_in);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    ptr_d     = ptr_q;
    haddr_d   = haddr_q;
    hcw_d     = hcw_q;
    wb_cw_d   = wb_cw_q;
    gnt_o     = 1'b0;
    rvalid_o  = 1'b0;
    rdata_o   = '0;
    rerr_sb_o = 1'b0;
    rerr_db_o = 1'b0;
    host_wr   = 1'b0;
    wb_en     = 1'b0;
    wb_addr   = haddr_q;
    sb_ev     = 1'b0;
    db_ev     = 1'b0;
    ev_addr   = haddr_q;
    case (state_q)
      ST_IDLE: begin
        gnt_o = req_i;
        if (scrub_en_i && (timer_q != TMAX)) timer_d = timer_q + TW'(1);
        if (req_i) begin
          if (we_i) begin
            host_wr = 1'b1;
          end else begin
            hcw_d   = mem_q[addr_i];
            haddr_d = addr_i;
            state_d = ST_HRD;
          end
        end else if (scrub_en_i && (timer_q == TMAX)) begin
          timer_d = '0;
          state_d = ST_SRD;
        end
      end
      ST_HRD: begin
        rvalid_o  = 1'b1;
        rdata_o   = dec.data;
        rerr_sb_o = dec.sb;
        rerr_db_o = dec.db;
        sb_ev     = dec.sb;
        db_ev     = dec.db;
        wb_cw_d   = secded_encode(dec.data);
        state_d   = dec.sb ? ST_HWB : ST_IDLE;
      end
      ST_HWB: begin
        wb_en   = 1'b1;
        state_d = ST_IDLE;
      end
      ST_SRD: begin
        sb_ev   = dec.sb;
        db_ev   = dec.db;
        ev_addr = ptr_q;
        wb_cw_d = secded_encode(dec.data);
        if (dec.sb) begin
          state_d = ST_SWB;
        end else begin
          ptr_d   = ptr_q + AW'(1);
          state_d = ST_IDLE;
        end
      end
      ST_SWB: begin
        wb_en   = 1'b1;
        wb_addr = ptr_q;
        ptr_d   = ptr_q + AW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write-back is applied last so a colliding injection is discarded.
  always_comb begin
    mem_d = mem_q;
    if (host_wr) mem_d[addr_i] = secded_encode(wdata_i);
    if (inj_i)   mem_d[inj_addr_i] = mem_d[inj_addr_i] ^ inj_mask_i;
    if (wb_en)   mem_d[wb_addr] = wb_cw_q;
  end

  always_comb begin
    db_addr_d = db_addr_q;
    irq_d     = irq_q;
    if (clr_i) begin
      db_addr_d = '0;
      irq_d     = 1'b0;
    end else if (db_ev) begin
      db_addr_d = ev_addr;
      irq_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      ptr_q     <= '0;
      haddr_q   <= '0;
      hcw_q     <= '0;
      wb_cw_q   <= '0;
      db_addr_q <= '0;
      irq_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ptr_q     <= ptr_d;
      haddr_q   <= haddr_d;
      hcw_q     <= hcw_d;
      wb_cw_q   <= wb_cw_d;
      db_addr_q <= db_addr_d;
      irq_q     <= irq_d;
      mem_q     <= mem_d;
    end
  end

  ecc_sat_counter #(.WIDTH(16)) u_sb_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (sb_ev),
    .clr_i  (clr_i),
    .cnt_o  (sb_cnt_o)
  );

  ecc_sat_counter #(.WIDTH(16)) u_db_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (db_ev),
    .clr_i  (clr_i),
    .cnt_o  (db_cnt_o)
  );

  assign db_addr_o = db_addr_q;
  assign irq_db_o  = irq_q;

endmodule

// File: tb/tb_ecc_scrub_mem.sv
// Directed self-checking bench for ecc_scrub_mem: host path, injection,
// double-bit reporting, scrubbing, host priority and counter saturation.
module tb_ecc_scrub_mem;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i;
  logic [3:0]  addr_i;
  logic [7:0]  wdata_i;
  logic        gnt_o, rvalid_o, rerr_sb_o, rerr_db_o;
  logic [7:0]  rdata_o;
  logic        scrub_en_i, inj_i, clr_i;
  logic [3:0]  inj_addr_i;
  logic [12:0] inj_mask_i;
  logic [15:0] sb_cnt_o, db_cnt_o;
  logic [3:0]  db_addr_o;
  logic        irq_db_o;

  logic        satInc, satClr;
  logic [3:0]  satCnt;

  int compCount = 0;
  int errCount  = 0;

  always #5 clk_i = ~clk_i;

  ecc_scrub_mem #(
    .K(8), .DEPTH(16), .SCRUB_INTERVAL(4)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .rerr_sb_o  (rerr_sb_o),
    .rerr_db_o  (rerr_db_o),
    .scrub_en_i (scrub_en_i),
    .inj_i      (inj_i),
    .inj_addr_i (inj_addr_i),
    .inj_mask_i (inj_mask_i),
    .clr_i      (clr_i),
    .sb_cnt_o   (sb_cnt_o),
    .db_cnt_o   (db_cnt_o),
    .db_addr_o  (db_addr_o),
    .irq_db_o   (irq_db_o)
  );

  ecc_sat_counter #(.WIDTH(4)) u_sat (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (satInc),
    .clr_i  (satClr),
    .cnt_o  (satCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [3:0] a, input logic [7:0] d);
    req_i   = req;
    we_i    = we;
    addr_i  = a;
    wdata_i = d;
  endtask

  task automatic hostWrite(input logic [3:0] a, input logic [7:0] d);
    applyStimulus(1'b1, 1'b1, a, d);
    #1 checkOutput("wr_gnt", gnt_o, 1);
    @(negedge clk_i);
    req_i = 1'b0;
  endtask

  task automatic injectBit(input logic [3:0] a, input logic [12:0] m);
    inj_i      = 1'b1;
    inj_addr_i = a;
    inj_mask_i = m;
    @(negedge clk_i);
    inj_i = 1'b0;
  endtask

  task automatic hostRead(input logic [3:0] a, input logic [7:0] expData,
                          input logic expSb, input logic expDb, input string tag);
    applyStimulus(1'b1, 1'b0, a, 8'h00);
    #1 checkOutput({tag, "_gnt"}, gnt_o, 1);
    @(negedge clk_i);
    req_i = 1'b0;
    #1;
    checkOutput({tag, "_rvalid"}, rvalid_o, 1);
    checkOutput({tag, "_rdata"}, rdata_o, expData);
    checkOutput({tag, "_sb"}, rerr_sb_o, expSb);
    checkOutput({tag, "_db"}, rerr_db_o, expDb);
    @(negedge clk_i);
    if (expSb) begin
      req_i = 1'b1;
      #1 checkOutput({tag, "_hwb_gnt"}, gnt_o, 0);
      req_i = 1'b0;
      @(negedge clk_i);
    end
  endtask

  // Single-bit read whose write-back cycle coincides with an injection.
  task automatic readInjHwb(input logic [3:0] a, input logic [7:0] expData,
                            input logic [3:0] injA, input logic [12:0] injM, input string tag);
    applyStimulus(1'b1, 1'b0, a, 8'h00);
    #1 checkOutput({tag, "_gnt"}, gnt_o, 1);
    @(negedge clk_i);
    req_i = 1'b0;
    #1;
    checkOutput({tag, "_sb"}, rerr_sb_o, 1);
    checkOutput({tag, "_rdata"}, rdata_o, expData);
    @(negedge clk_i);
    inj_i      = 1'b1;
    inj_addr_i = injA;
    inj_mask_i = injM;
    @(negedge clk_i);
    inj_i = 1'b0;
  endtask

  task automatic waitSbCount(input logic [15:0] target, input int budget, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_i);
      #1;
      if (sb_cnt_o == target) found = 1'b1;
    end
    checkOutput(tag, sb_cnt_o, target);
  endtask

  initial begin
    rst_ni = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
    scrub_en_i = 1'b0;
    inj_i = 1'b0; inj_addr_i = '0; inj_mask_i = '0;
    clr_i = 1'b0; satInc = 1'b0; satClr = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checkOutput("rst_gnt", gnt_o, 0);
    checkOutput("rst_rvalid", rvalid_o, 0);
    checkOutput("rst_rdata", rdata_o, 0);
    checkOutput("rst_sb_cnt", sb_cnt_o, 0);
    checkOutput("rst_db_cnt", db_cnt_o, 0);
    checkOutput("rst_db_addr", db_addr_o, 0);
    checkOutput("rst_irq", irq_db_o, 0);
    @(negedge clk_i);

    hostRead(4'd9, 8'h00, 0, 0, "rd_blank");
    hostWrite(4'd3, 8'hA5);
    hostRead(4'd3, 8'hA5, 0, 0, "rd_a5");

    hostWrite(4'd5, 8'h3C);
    injectBit(4'd5, 13'h0004);
    hostRead(4'd5, 8'h3C, 1, 0, "rd_sb5");
    checkOutput("sb_cnt_1", sb_cnt_o, 1);
    hostRead(4'd5, 8'h3C, 0, 0, "rd_sb5_fixed");

    inj_i = 1'b1; inj_addr_i = 4'd2; inj_mask_i = 13'h0001;
    hostWrite(4'd2, 8'h11);
    inj_i = 1'b0;
    hostRead(4'd2, 8'h11, 1, 0, "rd_wr_inj");
    checkOutput("sb_cnt_2", sb_cnt_o, 2);

    injectBit(4'd5, 13'h0100);
    readInjHwb(4'd5, 8'h3C, 4'd5, 13'h0200, "hwb_same");
    hostRead(4'd5, 8'h3C, 0, 0, "rd_inj_dropped");
    injectBit(4'd5, 13'h0040);
    readInjHwb(4'd5, 8'h3C, 4'd6, 13'h0400, "hwb_other");
    hostRead(4'd6, 8'h00, 1, 0, "rd_inj_applied");
    checkOutput("sb_cnt_5", sb_cnt_o, 5);

    hostWrite(4'd7, 8'h3C);
    injectBit(4'd7, 13'h0006);
    hostRead(4'd7, 8'h3C, 0, 1, "rd_db7");
    checkOutput("db_cnt_1", db_cnt_o, 1);
    checkOutput("db_addr_7", db_addr_o, 7);
    checkOutput("irq_set", irq_db_o, 1);
    checkOutput("sb_cnt_after_db", sb_cnt_o, 5);
    hostRead(4'd7, 8'h3C, 0, 1, "rd_db7_again");
    checkOutput("db_cnt_2", db_cnt_o, 2);
    checkOutput("irq_sticky", irq_db_o, 1);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    #1;
    checkOutput("clr_irq", irq_db_o, 0);
    checkOutput("clr_db_cnt", db_cnt_o, 0);
    checkOutput("clr_db_addr", db_addr_o, 0);
    checkOutput("clr_sb_cnt", sb_cnt_o, 0);
    hostWrite(4'd7, 8'h3C);

    injectBit(4'd0, 13'h0010);
    injectBit(4'd15, 13'h1000);
    scrub_en_i = 1'b1;
    waitSbCount(16'd2, 96, "scrub_sweep");
    scrub_en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    hostRead(4'd0, 8'h00, 0, 0, "scrub_fix0");
    hostRead(4'd15, 8'h00, 0, 0, "scrub_fix15");
    checkOutput("scrub_db_cnt", db_cnt_o, 0);

    injectBit(4'd0, 13'h0020);
    scrub_en_i = 1'b1;
    waitSbCount(16'd3, 96, "scrub_wrap");
    scrub_en_i = 1'b0;
    repeat (3) @(negedge clk_i);

    injectBit(4'd1, 13'h0008);
    scrub_en_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'd3, 8'h00);
    for (int i = 0; i < 24; i++) begin
      #1;
      checkOutput("hold_gnt", gnt_o, (i % 2 == 0));
      checkOutput("hold_rvalid", rvalid_o, (i % 2 == 1));
      @(negedge clk_i);
    end
    #1 checkOutput("hold_no_scrub", sb_cnt_o, 3);
    req_i = 1'b0;
    waitSbCount(16'd4, 10, "hold_release");
    scrub_en_i = 1'b0;
    repeat (3) @(negedge clk_i);

    injectBit(4'd5, 13'h0001);
    applyStimulus(1'b1, 1'b0, 4'd5, 8'h00);
    @(negedge clk_i);
    req_i = 1'b0;
    clr_i = 1'b1;
    #1 checkOutput("clr_inc_sb", rerr_sb_o, 1);
    @(negedge clk_i);
    clr_i = 1'b0;
    #1 checkOutput("clr_beats_inc", sb_cnt_o, 0);
    @(negedge clk_i);

    satInc = 1'b1;
    repeat (20) @(negedge clk_i);
    #1 checkOutput("sat_hold", satCnt, 4'hF);
    satClr = 1'b1;
    @(negedge clk_i);
    #1 checkOutput("sat_clr_prio", satCnt, 0);
    satClr = 1'b0;
    @(negedge clk_i);
    #1 checkOutput("sat_restart", satCnt, 1);
    satInc = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
